multicycle_ctrl: RTL

//  Control FSM that sequences the RV32I datapath over several cycles: instruction fetch, decode, execute, memory, writeback.

---
 rtl/multicycle_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, counters, traps.
// Latency: B 3 cycles, R/I/U/J/store 4, load 5 (zero-wait acks); memory waits stretch FETCH/MEM.
// Backpressure: imem_req/dmem_req held until the matching 1-cycle ack; no ack within MAX_WAIT -> TRAP.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   inst, br_taken             instruction register contents, branch comparator result
//   imem_ack, dmem_ack         memory ack pulses
//   imem_req, dmem_req, dmem_we, ir_we        memory handshakes and IR latch
//   imm_sel, alu_a_sel, alu_b_sel, wb_sel     datapath mux selects
//   reg_we, pc_we, pc_sel, retire             architectural update strobes
//   illegal_inst, bus_err      sticky trap causes
//   state, cycle_cnt, instret_cnt             FSM state and performance counters
module multicycle_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       wb_sel,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic             illegal_inst,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    T_R, T_LOAD, T_IARITH, T_JALR, T_LUI, T_AUIPC, T_STORE, T_BRANCH, T_JAL, T_ILL
  } itype_t;

  // Counter only has to reach MAX_WAIT-1: the trap fires on the unacked
  // cycle that would bring it to MAX_WAIT.
  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  state_t            state_q, state_d;
  itype_t            ity;
  logic [WAIT_W-1:0] wait_q;
  logic              req_pending, ack_in, timeout;
  logic              imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, reg_we_c, pc_we_c;
  logic              unused_inst;

  assign unused_inst = ^inst[31:7];

  always_comb begin
    case (inst[6:0])
      7'b0110011: ity = T_R;
      7'b0000011: ity = T_LOAD;
      7'b0010011: ity = T_IARITH;
      7'b1100111: ity = T_JALR;
      7'b0110111: ity = T_LUI;
      7'b0010111: ity = T_AUIPC;
      7'b0100011: ity = T_STORE;
      7'b1100011: ity = T_BRANCH;
      7'b1101111: ity = T_JAL;
      default:    ity = T_ILL;
    endcase
  end

  assign req_pending = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack_in      = (state_q == S_FETCH) ? imem_ack : dmem_ack;
  // An ack in the limit cycle wins because timeout requires !ack_in.
  assign timeout     = (MAX_WAIT != 0) && req_pending && !ack_in && (wait_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel     = 2'd0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 1'b0;
    wb_sel     = 2'd0;
    imm_sel    = 3'd0;

    // Immediate format is held for the whole life of the instruction.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      case (ity)
        T_LOAD, T_IARITH, T_JALR: imm_sel = 3'd1;
        T_STORE:                  imm_sel = 3'd2;
        T_BRANCH:                 imm_sel = 3'd3;
        T_LUI, T_AUIPC:           imm_sel = 3'd4;
        T_JAL:                    imm_sel = 3'd5;
        default:                  imm_sel = 3'd0;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = (ity == T_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (ity)
          T_IARITH, T_LOAD, T_STORE, T_JALR: alu_b_sel = 1'b1;
          T_AUIPC: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
          end
          default: ;
        endcase
        if (ity == T_BRANCH) begin
          pc_we_c = 1'b1;
          pc_sel  = br_taken ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (ity == T_LOAD || ity == T_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (ity == T_STORE);
        if (dmem_ack) begin
          if (ity == T_STORE) begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        case (ity)
          T_LOAD:        wb_sel = 2'd1;
          T_JAL, T_JALR: wb_sel = 2'd2;
          T_LUI:         wb_sel = 2'd3;
          default:       wb_sel = 2'd0;
        endcase
        case (ity)
          T_JAL:   pc_sel = 2'd1;
          T_JALR:  pc_sel = 2'd2;
          default: pc_sel = 2'd0;
        endcase
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes and requests are masked during reset so an aborted instruction
  // never updates architectural state.
  assign imem_req = rst_n & imem_req_c;
  assign dmem_req = rst_n & dmem_req_c;
  assign dmem_we  = rst_n & dmem_we_c;
  assign ir_we    = rst_n & ir_we_c;
  assign reg_we   = rst_n & reg_we_c;
  assign pc_we    = rst_n & pc_we_c;
  assign retire   = rst_n & pc_we_c;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      wait_q       <= '0;
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
      illegal_inst <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (req_pending && !ack_in)
        wait_q <= wait_q + WAIT_W'(1);
      if (state_q != S_TRAP)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pc_we_c)
        instret_cnt <= instret_cnt + CNT_W'(1);
      if (state_q == S_DECODE && ity == T_ILL)
        illegal_inst <= 1'b1;
      if (timeout)
        bus_err <= 1'b1;
    end
  end

endmodule
